// File: rtl/vram_arb_mem.sv
// Video RAM with power-on clear engine; render port has fixed-latency priority reads,
// CPU port uses req/ack with byte-enabled writes and a starvation-forced grant.
module vram_arb_mem #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 15,
  parameter int RD_LAT     = 2,
  parameter int INIT_ZERO  = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rp_re,
  input  logic [ADDR_W-1:0]   rp_addr,
  output logic                rp_stall,
  output logic                rp_valid,
  output logic [DATA_W-1:0]   rp_data,
  input  logic                cp_req,
  input  logic                cp_we,
  input  logic [DATA_W/8-1:0] cp_be,
  input  logic [ADDR_W-1:0]   cp_addr,
  input  logic [DATA_W-1:0]   cp_wdata,
  output logic                cp_ack,
  output logic [DATA_W-1:0]   cp_rdata,
  output logic                clr_busy
);

  localparam int NB = DATA_W / 8;
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;
  localparam logic [0:0] S_INIT  = (INIT_ZERO != 0) ? S_CLEAR : S_RUN;
  localparam logic [7:0] SMAX    = 8'(STARVE_MAX);

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_addr;
  logic [7:0]        starve_cnt;
  logic              wr_pend;
  logic [RD_LAT-1:0] rv;
  logic [RD_LAT-1:0] cv;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] dq  [RD_LAT];

  logic run;
  logic clearing;
  logic cp_busy;
  logic cp_grant;
  logic rp_acc;
  logic rd_en;

  // The ack cycle itself still counts as in flight; a held cp_req is only a new request after it.
  always_comb begin
    run      = (state == S_RUN) && !reset;
    clearing = (state == S_CLEAR) && !reset;
    cp_busy  = wr_pend || (|cv) || cp_ack;
    cp_grant = run && cp_req && !cp_busy && (!rp_re || (starve_cnt == SMAX));
    rp_acc   = run && rp_re && !cp_grant;
    rd_en    = rp_acc || (cp_grant && !cp_we);
  end

  assign rp_stall = run && rp_re && cp_grant;
  assign clr_busy = (state == S_CLEAR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_INIT;
      clr_addr   <= '0;
      starve_cnt <= '0;
      wr_pend    <= 1'b0;
      rv         <= '0;
      cv         <= '0;
      rp_valid   <= 1'b0;
      rp_data    <= '0;
      cp_ack     <= 1'b0;
      cp_rdata   <= '0;
    end else begin
      if (state == S_CLEAR) begin
        clr_addr <= clr_addr + ADDR_W'(1);
        if (&clr_addr) state <= S_RUN;
      end

      if (cp_grant)
        starve_cnt <= '0;
      else if (run && cp_req && !cp_busy && (starve_cnt != SMAX))
        starve_cnt <= starve_cnt + 8'd1;

      wr_pend <= cp_grant && cp_we;
      rv[0]   <= rp_acc;
      cv[0]   <= cp_grant && !cp_we;
      for (int k = 1; k < RD_LAT; k++) begin
        rv[k] <= rv[k-1];
        cv[k] <= cv[k-1];
      end

      rp_valid <= rv[RD_LAT-1];
      if (rv[RD_LAT-1]) rp_data <= dq[RD_LAT-1];
      cp_ack <= wr_pend || cv[RD_LAT-1];
      if (cv[RD_LAT-1]) cp_rdata <= dq[RD_LAT-1];
    end
  end

  // Single port: exactly one of clear write, CPU write or read happens per cycle.
  always_ff @(posedge clock) begin
    if (clearing) begin
      mem[clr_addr] <= '0;
    end else if (cp_grant && cp_we) begin
      for (int b = 0; b < NB; b++)
        if (cp_be[b]) mem[cp_addr][b*8 +: 8] <= cp_wdata[b*8 +: 8];
    end
    if (rd_en) dq[0] <= mem[cp_grant ? cp_addr : rp_addr];
    for (int k = 1; k < RD_LAT; k++) dq[k] <= dq[k-1];
  end

endmodule
